pim_conv1x1_sliced: RTL and testbench

PIM_CONV1X1_SLICED -- requirements
Module: pim_conv1x1_sliced

---
 rtl/pim_pkg.sv | 33 +++
 rtl/pim_slice_unit.sv | 109 ++++++++++
 rtl/pim_conv1x1_sliced.sv | 174 +++++++++++++++++
 tb/tb_pim_conv1x1_sliced.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pim_pkg.sv
// ---------------------------------------------------------------------------
// pim_pkg
// Shared definitions for the bit-sliced 1x1 convolution PIM block:
//   - pim_state_e : controller state encoding
//   - clogb2      : address width helper (never returns less than 1)
//   - out_width   : width of the shift-added result
// Optional build macro used by the block: PIM_ADC_SAT_EN (ADC clamps).
// ---------------------------------------------------------------------------
package pim_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } pim_state_e;

    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    // HH sits 2*SLICE_W above LL; HL+LH can carry one extra bit, plus one
    // bit for the final add.
    function automatic int out_width(input int slice_w, input int adc_p);
        return 2 * slice_w + adc_p + 2;
    endfunction

endpackage

// File: rtl/pim_slice_unit.sv
// ---------------------------------------------------------------------------
// pim_slice_unit
// One bit-slice crossbar: stores one SLICE_W slice of every weight, forms
// the dot product of an activation slice vector with the addressed row and
// registers it through an ADP_P-bit ADC stage.
// Build macro: PIM_ADC_SAT_EN -- defined: clamp to 2^ADC_P-1 and flag it;
//                                undefined: keep the ADC_P LSBs, flag tied 0.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset (clears weights)
//   wr_en_i       write the slice row at wr_addr_i from wr_slice_i
//   act_slice_i   activation slices, channel c at [c*SLICE_W +: SLICE_W]
//   rd_addr_i     row fed to the MAC
//   adv_i         load the ADC register (pipeline advance)
//   adc_o, sat_o  registered ADC code and clamp indication
// ---------------------------------------------------------------------------
module pim_slice_unit
    import pim_pkg::*;
#(
    parameter int SLICE_W = 3,
    parameter int N_CH    = 9,
    parameter int DEPTH   = 4,
    parameter int ADC_P   = 6,
    parameter int AW      = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en_i,
    input  logic [AW-1:0]             wr_addr_i,
    input  logic [N_CH*SLICE_W-1:0]   wr_slice_i,
    input  logic [N_CH*SLICE_W-1:0]   act_slice_i,
    input  logic [AW-1:0]             rd_addr_i,
    input  logic                      adv_i,
    output logic [ADC_P-1:0]          adc_o,
    output logic                      sat_o
);

`ifdef PIM_ADC_SAT_EN
    localparam int PSUM_W  = 2 * SLICE_W + clogb2(N_CH);
    localparam int ACC_W   = PSUM_W;
    localparam int ADC_MAX = (1 << ADC_P) - 1;
`else
    // Accumulating modulo 2^ADC_P gives exactly the truncated full sum.
    localparam int ACC_W   = ADC_P;
`endif

    logic [DEPTH*N_CH*SLICE_W-1:0] w_flat;
    logic [ACC_W-1:0]              acc;
    logic [ACC_W-1:0]              a_ext;
    logic [ACC_W-1:0]              w_ext;
    logic [ADC_P-1:0]              adc_d;
    logic                          sat_d;
    logic [ADC_P-1:0]              adc_q;
    logic                          sat_q;

    for (genvar r = 0; r < DEPTH; r++) begin : g_row
        for (genvar c = 0; c < N_CH; c++) begin : g_ch
            logic [SLICE_W-1:0] cell_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cell_q <= '0;
                end else if (wr_en_i && (wr_addr_i == AW'(r))) begin
                    cell_q <= wr_slice_i[c*SLICE_W +: SLICE_W];
                end
            end

            assign w_flat[(r*N_CH + c)*SLICE_W +: SLICE_W] = cell_q;
        end
    end

    always_comb begin
        acc   = '0;
        a_ext = '0;
        w_ext = '0;
        for (int c = 0; c < N_CH; c++) begin
            a_ext = ACC_W'(act_slice_i[c*SLICE_W +: SLICE_W]);
            w_ext = ACC_W'(w_flat[(int'(rd_addr_i)*N_CH + c)*SLICE_W +: SLICE_W]);
            acc   = acc + a_ext * w_ext;
        end
    end

`ifdef PIM_ADC_SAT_EN
    always_comb begin
        adc_d = ADC_P'(acc);
        sat_d = 1'b0;
        if (acc > ACC_W'(ADC_MAX)) begin
            adc_d = '1;
            sat_d = 1'b1;
        end
    end
`else
    assign adc_d = acc;
    assign sat_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            adc_q <= '0;
            sat_q <= 1'b0;
        end else if (adv_i) begin
            adc_q <= adc_d;
            sat_q <= sat_d;
        end
    end

    assign adc_o = adc_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/pim_conv1x1_sliced.sv
// ---------------------------------------------------------------------------
// pim_conv1x1_sliced
// 1x1 convolution on a bit-sliced PIM crossbar. An accepted activation
// vector is multiplied against every stored weight row; each row result is
// built from four slice partials (HH, HL, LH, LL) and shift-added.
// Build macro: PIM_ADC_SAT_EN (ADC clamping + sat_flag reporting).
//
// State table
//   state   | meaning
//   ST_IDLE | in_ready=1, weight writes allowed, waiting for a vector
//   ST_RUN  | rows issued / results streamed; leaves when out_last accepted
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     activation vector handshake, in_data N_CH*DATA_W
//   wr_en/wr_addr/wr_data weight row write (honoured in IDLE only)
//   out_valid/out_ready   result handshake
//   out_data/out_addr     shift-added result and its row
//   out_last              marks row DEPTH-1
//   sat_flag              some slice ADC clamped for this result
// ---------------------------------------------------------------------------
module pim_conv1x1_sliced
    import pim_pkg::*;
#(
    parameter int DATA_W  = 6,
    parameter int SLICE_W = 3,
    parameter int N_CH    = 9,
    parameter int DEPTH   = 4,
    parameter int ADC_P   = 6,
    localparam int AW     = clogb2(DEPTH),
    localparam int OUT_W  = out_width(SLICE_W, ADC_P)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [N_CH*DATA_W-1:0]   wr_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic [AW-1:0]            out_addr,
    output logic                     out_last,
    output logic                     sat_flag
);

    if (DATA_W != 2 * SLICE_W) begin : g_bad_width
        $error("pim_conv1x1_sliced: DATA_W must equal 2*SLICE_W");
    end

    localparam logic [AW-1:0] ROW_LAST = AW'(DEPTH - 1);

    pim_state_e state_q, state_d;

    logic [N_CH*DATA_W-1:0]  act_q;
    logic [AW-1:0]           row_q;
    logic                    issue_q;
    logic                    v1_q;
    logic [AW-1:0]           a1_q;
    logic                    out_valid_q;
    logic [OUT_W-1:0]        out_data_q;
    logic [AW-1:0]           out_addr_q;
    logic                    out_last_q;
    logic                    sat_q;

    logic                    accept;
    logic                    adv;
    logic                    wr_ok;
    logic [OUT_W-1:0]        sum;
    logic                    sat_any;

    logic [N_CH*SLICE_W-1:0] act_hi, act_lo, wr_hi, wr_lo;
    logic [ADC_P-1:0]        p_hh, p_hl, p_lh, p_ll;
    logic                    s_hh, s_hl, s_lh, s_ll;

    assign in_ready = (state_q == ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign wr_ok    = wr_en && (state_q == ST_IDLE);
    // The whole pipeline (row counter, ADC stage, output stage) moves together,
    // so a stalled output freezes everything behind it.
    assign adv      = !out_valid_q || out_ready;

    for (genvar c = 0; c < N_CH; c++) begin : g_split
        assign act_hi[c*SLICE_W +: SLICE_W] = act_q[c*DATA_W + SLICE_W +: SLICE_W];
        assign act_lo[c*SLICE_W +: SLICE_W] = act_q[c*DATA_W +: SLICE_W];
        assign wr_hi[c*SLICE_W +: SLICE_W]  = wr_data[c*DATA_W + SLICE_W +: SLICE_W];
        assign wr_lo[c*SLICE_W +: SLICE_W]  = wr_data[c*DATA_W +: SLICE_W];
    end

    pim_slice_unit #(.SLICE_W(SLICE_W), .N_CH(N_CH), .DEPTH(DEPTH), .ADC_P(ADC_P), .AW(AW)) u_hh (
        .clk(clk), .rst_n(rst_n), .wr_en_i(wr_ok), .wr_addr_i(wr_addr), .wr_slice_i(wr_hi),
        .act_slice_i(act_hi), .rd_addr_i(row_q), .adv_i(adv), .adc_o(p_hh), .sat_o(s_hh)
    );

    pim_slice_unit #(.SLICE_W(SLICE_W), .N_CH(N_CH), .DEPTH(DEPTH), .ADC_P(ADC_P), .AW(AW)) u_hl (
        .clk(clk), .rst_n(rst_n), .wr_en_i(wr_ok), .wr_addr_i(wr_addr), .wr_slice_i(wr_lo),
        .act_slice_i(act_hi), .rd_addr_i(row_q), .adv_i(adv), .adc_o(p_hl), .sat_o(s_hl)
    );

    pim_slice_unit #(.SLICE_W(SLICE_W), .N_CH(N_CH), .DEPTH(DEPTH), .ADC_P(ADC_P), .AW(AW)) u_lh (
        .clk(clk), .rst_n(rst_n), .wr_en_i(wr_ok), .wr_addr_i(wr_addr), .wr_slice_i(wr_hi),
        .act_slice_i(act_lo), .rd_addr_i(row_q), .adv_i(adv), .adc_o(p_lh), .sat_o(s_lh)
    );

    pim_slice_unit #(.SLICE_W(SLICE_W), .N_CH(N_CH), .DEPTH(DEPTH), .ADC_P(ADC_P), .AW(AW)) u_ll (
        .clk(clk), .rst_n(rst_n), .wr_en_i(wr_ok), .wr_addr_i(wr_addr), .wr_slice_i(wr_lo),
        .act_slice_i(act_lo), .rd_addr_i(row_q), .adv_i(adv), .adc_o(p_ll), .sat_o(s_ll)
    );

    assign sum = (OUT_W'(p_hh) << (2 * SLICE_W))
               + ((OUT_W'(p_hl) + OUT_W'(p_lh)) << SLICE_W)
               + OUT_W'(p_ll);
    assign sat_any = s_hh | s_hl | s_lh | s_ll;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_RUN;
            ST_RUN:  if (out_valid_q && out_ready && out_last_q) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            act_q       <= '0;
            row_q       <= '0;
            issue_q     <= 1'b0;
            v1_q        <= 1'b0;
            a1_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q <= state_d;

            if (accept) begin
                act_q   <= in_data;
                row_q   <= '0;
                issue_q <= 1'b1;
            end else if (adv && issue_q) begin
                if (row_q == ROW_LAST) begin
                    issue_q <= 1'b0;
                end else begin
                    row_q <= row_q + 1'b1;
                end
            end

            if (adv) begin
                v1_q        <= issue_q;
                a1_q        <= row_q;
                out_valid_q <= v1_q;
                if (v1_q) begin
                    out_data_q <= sum;
                    out_addr_q <= a1_q;
                    out_last_q <= (a1_q == ROW_LAST);
                    sat_q      <= sat_any;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_last  = out_last_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_pim_conv1x1_sliced.sv
module tb_pim_conv1x1_sliced;

    localparam int DATA_W  = 6;
    localparam int SLICE_W = 3;
    localparam int N_CH    = 9;
    localparam int DEPTH   = 4;
    localparam int ADC_P   = 6;
    localparam int AW      = 2;
    localparam int OUT_W   = 14;
    localparam int SL      = 1 << SLICE_W;
    localparam int ADC_MAX = (1 << ADC_P) - 1;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [N_CH*DATA_W-1:0] in_data = '0;
    logic                   wr_en = 1'b0;
    logic [AW-1:0]          wr_addr = '0;
    logic [N_CH*DATA_W-1:0] wr_data = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [OUT_W-1:0]       out_data;
    logic [AW-1:0]          out_addr;
    logic                   out_last;
    logic                   sat_flag;

    pim_conv1x1_sliced dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int addr;
        bit last;
        bit sat;
    } exp_t;

    exp_t exp_q[$];
    int   wt [DEPTH][N_CH];
    int   act [N_CH];
    int   wvals [N_CH];
    int   nvec = 0;
    int   nerr = 0;
    int   beats = 0;

    task automatic check(input string name, input logic [31:0] got, input int want);
        nvec++;
        if (got !== 32'(want)) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    function automatic int adc_model(input int p, output bit clip);
`ifdef PIM_ADC_SAT_EN
        clip = (p > ADC_MAX);
        return clip ? ADC_MAX : p;
`else
        clip = 1'b0;
        return p % (ADC_MAX + 1);
`endif
    endfunction

    function automatic void push_expected();
        for (int r = 0; r < DEPTH; r++) begin
            int  hh, hl, lh, ll, ah, al, wh, wl;
            bit  c0, c1, c2, c3;
            exp_t e;
            hh = 0; hl = 0; lh = 0; ll = 0;
            for (int c = 0; c < N_CH; c++) begin
                ah = act[c] / SL;
                al = act[c] % SL;
                wh = wt[r][c] / SL;
                wl = wt[r][c] % SL;
                hh += ah * wh;
                hl += ah * wl;
                lh += al * wh;
                ll += al * wl;
            end
            hh = adc_model(hh, c0);
            hl = adc_model(hl, c1);
            lh = adc_model(lh, c2);
            ll = adc_model(ll, c3);
            e.data = hh * SL * SL + (hl + lh) * SL + ll;
            e.addr = r;
            e.last = (r == DEPTH - 1);
            e.sat  = c0 | c1 | c2 | c3;
            exp_q.push_back(e);
        end
    endfunction

    function automatic logic [N_CH*DATA_W-1:0] pack(input int v [N_CH]);
        logic [N_CH*DATA_W-1:0] p;
        p = '0;
        for (int c = 0; c < N_CH; c++) p[c*DATA_W +: DATA_W] = DATA_W'(v[c]);
        return p;
    endfunction

    // Scoreboard monitor: compares whatever is presented against the head of
    // the queue; during a stall the same head is checked every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_beat: got data %0d addr %0d, expected no beat", out_data, out_addr);
            end else begin
                e = exp_q[0];
                check("out_data", 32'(out_data), e.data);
                check("out_addr", 32'(out_addr), e.addr);
                check("out_last", 32'(out_last), int'(e.last));
                check("sat_flag", 32'(sat_flag), int'(e.sat));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    beats++;
                end
            end
        end
    end

    task automatic clear_model();
        for (int r = 0; r < DEPTH; r++)
            for (int c = 0; c < N_CH; c++) wt[r][c] = 0;
        exp_q.delete();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; in_valid = 1'b0; wr_en = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_addr", 32'(out_addr), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_sat_flag", 32'(sat_flag), 0);
        clear_model();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic write_row(input int r);
        wr_en = 1'b1;
        wr_addr = AW'(r);
        wr_data = pack(wvals);
        for (int c = 0; c < N_CH; c++) wt[r][c] = wvals[c];
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic fill_w(input int v);
        for (int c = 0; c < N_CH; c++) wvals[c] = v;
    endtask

    task automatic rand_w();
        for (int c = 0; c < N_CH; c++) wvals[c] = int'($urandom_range(0, 63));
    endtask

    task automatic fill_act(input int v);
        for (int c = 0; c < N_CH; c++) act[c] = v;
    endtask

    task automatic rand_act();
        for (int c = 0; c < N_CH; c++) act[c] = int'($urandom_range(0, 63));
    endtask

    // mode 0: out_ready always high; 1: random; 2: hold low 3 cycles on beat 2
    task automatic launch(input int mode, input bit wr_same, input int wr_row,
                          input bit mid_wr, input bit abort);
        bit done;
        int stall_left;
        int junk [N_CH];
        stall_left = 3;
        beats = 0;
        check("in_ready_idle", 32'(in_ready), 1);
        in_data = pack(act);
        in_valid = 1'b1;
        if (wr_same) begin
            wr_en = 1'b1;
            wr_addr = AW'(wr_row);
            wr_data = pack(wvals);
            for (int c = 0; c < N_CH; c++) wt[wr_row][c] = wvals[c];
        end
        push_expected();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wr_en = 1'b0;
        check("in_ready_run", 32'(in_ready), 0);
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            if (k == 1) check("latency_e1_valid", 32'(out_valid), 0);
            if (k == 2) check("latency_e2_valid", 32'(out_valid), 1);
            if (abort && out_valid && beats == 1) begin
                rst_n = 1'b0;
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                check("abort_out_valid", 32'(out_valid), 0);
                check("abort_in_ready", 32'(in_ready), 1);
                check("abort_out_data", 32'(out_data), 0);
                clear_model();
                rst_n = 1'b1;
                done = 1'b1;
            end else begin
                case (mode)
                    0: out_ready = 1'b1;
                    1: out_ready = ($urandom_range(0, 3) != 0);
                    default: begin
                        if (out_valid && beats == 1 && stall_left > 0) begin
                            out_ready = 1'b0;
                            stall_left--;
                        end else begin
                            out_ready = 1'b1;
                        end
                    end
                endcase
                if (mid_wr && k == 3) begin
                    for (int c = 0; c < N_CH; c++) junk[c] = int'($urandom_range(0, 63));
                    wr_en = 1'b1;
                    wr_addr = '0;
                    wr_data = pack(junk);
                end else begin
                    wr_en = 1'b0;
                end
                if (k > 0 && exp_q.size() == 0 && in_ready) begin
                    done = 1'b1;
                end else begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        wr_en = 1'b0;
        if (!done) begin
            nvec++;
            nerr++;
            $display("FAIL timeout: %0d beats outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        reset_dut();

        fill_w(1);
        for (int r = 0; r < DEPTH; r++) write_row(r);
        fill_act(1);
        launch(0, 1'b0, 0, 1'b0, 1'b0);

        fill_w(0);
        wvals[0] = 63;
        for (int r = 0; r < DEPTH; r++) write_row(r);
        fill_act(0);
        act[0] = 63;
        launch(0, 1'b0, 0, 1'b0, 1'b0);

        fill_w(63);
        for (int r = 0; r < DEPTH; r++) write_row(r);
        fill_act(63);
        launch(1, 1'b0, 0, 1'b0, 1'b0);

        for (int r = 0; r < DEPTH; r++) begin
            rand_w();
            write_row(r);
        end
        rand_act();
        launch(2, 1'b0, 0, 1'b0, 1'b0);

        rand_act();
        launch(0, 1'b0, 0, 1'b1, 1'b0);
        rand_act();
        launch(1, 1'b0, 0, 1'b0, 1'b0);

        rand_w();
        rand_act();
        launch(0, 1'b1, 2, 1'b0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            for (int n = int'($urandom_range(0, 2)); n > 0; n--) begin
                rand_w();
                write_row(int'($urandom_range(0, DEPTH - 1)));
            end
            rand_w();
            rand_act();
            launch(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, DEPTH - 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        rand_act();
        launch(0, 1'b0, 0, 1'b0, 1'b1);
        fill_act(63);
        launch(0, 1'b0, 0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
